// File: rtl/partial_product_calc_proc.sv
// Registered partial-product stage of a signed sequential shift-add multiplier.
// Optional registered last_step output is enabled by defining PPCP_LAST_STEP_FLAG_EN.
module partial_product_calc_proc #(
    parameter int W     = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             a_bit,
    input  logic [W-1:0]     b,
    input  logic [CNT_W-1:0] count,
    output logic [W-1:0]     pp,
    output logic [W:0]       processed_pp,
    output logic             out_valid
`ifdef PPCP_LAST_STEP_FLAG_EN
    ,
    output logic             last_step
`endif
);

    logic [W-1:0] w_pp_next;
    logic [W:0]   w_ext;
    logic [W:0]   w_neg;
    logic [W:0]   w_processed_next;
    logic         w_is_last;

    logic [W-1:0] r_pp;
    logic [W:0]   r_processed_pp;
    logic         r_out_valid;

    // The multiplier MSB carries negative weight, so the last step subtracts.
    // The idle code and other counts above W-1 never match and stay unnegated.
    assign w_pp_next        = b & {W{a_bit}};
    assign w_ext            = {w_pp_next[W-1], w_pp_next};
    assign w_neg            = ~w_ext + (W+1)'(1);
    assign w_is_last        = (count == CNT_W'(W - 1));
    assign w_processed_next = w_is_last ? w_neg : w_ext;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pp           <= '0;
            r_processed_pp <= '0;
            r_out_valid    <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_pp           <= w_pp_next;
                r_processed_pp <= w_processed_next;
            end
        end
    end

    assign pp           = r_pp;
    assign processed_pp = r_processed_pp;
    assign out_valid    = r_out_valid;

`ifdef PPCP_LAST_STEP_FLAG_EN
    logic r_last_step;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_step <= 1'b0;
        end else if (in_valid) begin
            r_last_step <= w_is_last;
        end
    end

    assign last_step = r_last_step;
`endif

endmodule

// File: tb/tb_partial_product_calc_proc.sv
// Directed self-checking bench for partial_product_calc_proc.
// Define PPCP_LAST_STEP_FLAG_EN to also check the optional last_step output.
module tb_partial_product_calc_proc;

    localparam int W     = 16;
    localparam int CNT_W = 5;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             a_bit;
    logic [W-1:0]     b;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     pp;
    logic [W:0]       processed_pp;
    logic             out_valid;
`ifdef PPCP_LAST_STEP_FLAG_EN
    logic             last_step;
`endif

    int checks = 0;
    int errors = 0;

    partial_product_calc_proc #(.W(W), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .a_bit        (a_bit),
        .b            (b),
        .count        (count),
        .pp           (pp),
        .processed_pp (processed_pp),
        .out_valid    (out_valid)
`ifdef PPCP_LAST_STEP_FLAG_EN
        ,
        .last_step    (last_step)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic a, input logic [W-1:0] bb,
                                 input logic [CNT_W-1:0] cnt);
        @(negedge clock);
        in_valid = v;
        a_bit    = a;
        b        = bb;
        count    = cnt;
        @(posedge clock);
        #1;
    endtask

    task automatic checkStep(input string tag, input logic [W-1:0] expPp,
                             input logic [W:0] expProc, input logic expValid,
                             input logic expLast);
        checkOutput({tag, "_pp"}, 32'(pp), 32'(expPp));
        checkOutput({tag, "_proc"}, 32'(processed_pp), 32'(expProc));
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(expValid));
`ifdef PPCP_LAST_STEP_FLAG_EN
        checkOutput({tag, "_last"}, 32'(last_step), 32'(expLast));
`else
        if (expLast === 1'bx) $display("[TB] unexpected unknown last flag in %s", tag);
`endif
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        a_bit    = 1'b0;
        b        = '0;
        count    = '0;
        #12;
        checkStep("reset", 16'h0000, 17'h00000, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        applyStimulus(1'b1, 1'b1, 16'h1234, 5'd0);
        checkStep("nonlast", 16'h1234, 17'h01234, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'hFFFF, 5'd15);
        checkStep("hold", 16'h1234, 17'h01234, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h8000, 5'd3);
        checkStep("negnonlast", 16'h8000, 17'h18000, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h8000, 5'd15);
        checkStep("lastmin", 16'h8000, 17'h08000, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h0001, 5'd15);
        checkStep("lastone", 16'h0001, 17'h1FFFF, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b0, 16'hFFFF, 5'd15);
        checkStep("lastzero", 16'h0000, 17'h00000, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h7FFF, 5'd15);
        checkStep("lastmax", 16'h7FFF, 17'h18001, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'hFFFF, 5'h1F);
        checkStep("idle", 16'hFFFF, 17'h1FFFF, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h0001, 5'd16);
        checkStep("cnt16", 16'h0001, 17'h00001, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h0005, 5'd14);
        checkStep("b2b14", 16'h0005, 17'h00005, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h0003, 5'd15);
        checkStep("b2b15", 16'h0003, 17'h1FFFD, 1'b1, 1'b1);

        // Reset pulse straddles a rising edge while a valid step is presented.
        @(negedge clock);
        in_valid = 1'b1;
        a_bit    = 1'b1;
        b        = 16'h00AA;
        count    = 5'd2;
        #1 reset_n = 1'b0;
        #1;
        checkStep("midreset", 16'h0000, 17'h00000, 1'b0, 1'b0);
        #4 reset_n = 1'b1;
        #1;
        checkStep("afterpulse", 16'h0000, 17'h00000, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h00AA, 5'd2);
        checkStep("postreset", 16'h00AA, 17'h000AA, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h00AA, 5'd15);
        checkStep("postlast", 16'h00AA, 17'h1FF56, 1'b1, 1'b1);

        applyStimulus(1'b0, 1'b0, 16'h0000, 5'd0);
        checkStep("finalhold", 16'h00AA, 17'h1FF56, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/partial_product_calc_proc.md
Name: partial_product_calc_proc

Overview:
- Registered partial-product stage for the sequential two's-complement (signed) shift-add array multiplier.
- Each cycle it gates multiplicand B with the current multiplier bit, producing the partial product.
- It sign-extends the partial product to W+1 bits; on the final step it negates it, because the multiplier MSB has negative weight.
- The multiplier datapath adds this result into the upper product bits.

Parameters:
- W, 16, operand width (half of the multiplier's product width n=32).
- CNT_W, 5, step-counter width; the all-ones value is the multiplier's idle code.

Ports:
- clock  input  1  rising-edge clock; the single clock of the block.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  capture enable for the current step.
- a_bit  input  1  current multiplier bit (LSB of the shifting multiplier register).
- b  input  W  multiplicand, two's complement.
- count  input  CNT_W  current step index, 0..W-1.
- pp  output  W  registered partial product.
- processed_pp  output  W+1  registered sign-extended partial product, negated on the last step.
- out_valid  output  1  pp/processed_pp updated by a valid step in the previous cycle.

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed): pp=0, processed_pp=0, out_valid=0. The outputs hold these values until the first valid capture after reset_n deasserts.
- Calc function: pp_next = b AND {W{a_bit}}, bitwise.
- Proc function:
  - ext = {pp_next[W-1], pp_next}, a W+1-bit sign extension.
  - If count == W-1: processed_next = (~ext + 1) mod 2^(W+1), the two's-complement negation.
  - Otherwise: processed_next = ext.
- Range of the negation: it is always representable. The most negative pp, -2^(W-1), negates to +2^(W-1) without overflow.
- Latency is exactly 1 cycle. On a rising clock edge with in_valid=1, pp and processed_pp take their next values and out_valid becomes 1.
- On a rising edge with in_valid=0: pp and processed_pp hold their previous values; out_valid becomes 0.
- Back-to-back valid steps are accepted every cycle; there is no backpressure and no internal state beyond the output registers.
- count values > W-1, including the all-ones idle code, are treated as non-last steps: sign extension only, no negation.
- When a_bit=0, pp=0 and processed_pp=0 regardless of count, since the negation of 0 is 0.
- If reset_n asserts mid-operation, the in-flight step is discarded; the outputs clear immediately.
- All arithmetic is unsigned modulo 2^(W+1) on the bit vector; no saturation.

Optional Feature:
- Macro: PPCP_LAST_STEP_FLAG_EN.
- When defined, the block adds an output last_step (1 bit, registered, reset 0).
  - last_step is 1 in the cycle after a valid capture with count == W-1.
  - last_step is 0 after a valid capture with any other count.
  - last_step holds its value when in_valid=0.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: reset_n=0 asserted asynchronously between clock edges -> pp=0x0000, processed_pp=0x00000, out_valid=0 immediately.
2. Non-last step: in_valid=1, a_bit=1, b=0x1234, count=0 -> next cycle pp=0x1234, processed_pp=0x01234, out_valid=1.
3. Negative operand, non-last step: a_bit=1, b=0x8000, count=3 -> pp=0x8000, processed_pp=0x18000.
4. Last step:
   - a_bit=1, b=0x8000, count=15 -> processed_pp=0x08000.
   - a_bit=1, b=0x0001, count=15 -> processed_pp=0x1FFFF.
   - a_bit=0, b=0xFFFF, count=15 -> processed_pp=0x00000.
5. Hold and idle code:
   - in_valid=0 after step 2 -> pp/processed_pp unchanged, out_valid=0.
   - in_valid=1, a_bit=1, b=0xFFFF, count=5'h1F -> processed_pp=0x1FFFF, with no negation.
6. Mid-operation reset: valid steps every cycle, then reset_n pulsed low for half a cycle -> outputs clear immediately. The first valid step after release produces correct values one cycle later. With PPCP_LAST_STEP_FLAG_EN defined, last_step=1 only after the count=15 step.
